// File: rtl/lab62soc_event_fifo_pio_if.sv
// lab62soc_event_fifo_pio_if: Avalon-MM slave bus bundle for the event FIFO PIO.
// Signals: address[1:0], chipselect, read_n, write_n, writedata[31:0] (master -> slave),
//          readdata[31:0] (slave -> master, zero read latency).
interface lab62soc_event_fifo_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/lab62soc_event_fifo_pio.sv
// lab62soc_event_fifo_pio: Avalon-MM input PIO that queues game event codes for the CPU to pop.
// Ports: clk, reset_n (async active-low), av (Avalon slave: DATA/STATUS/IRQ_MASK/addr3),
//        in_data/in_valid/in_ready (event push side), irq (registered level interrupt).
// Optional: define EVENT_FIFO_PIO_THRESH_IRQ_EN for the THRESH register at address 3
//           and the count >= THRESH interrupt source enabled by IRQ_MASK bit 1.
module lab62soc_event_fifo_pio #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    lab62soc_event_fifo_pio_if.slave  av,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      irq
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              overflow, overflow_nxt;
    logic [1:0]        irq_mask, irq_mask_nxt;
    logic              irq_nxt;
    logic              empty, full, rd_stb, wr_stb, pop, push;
    logic [31:0]       data_word, status_word, addr3_word;
    logic              unused_ok;

    assign unused_ok = ^av.writedata;

    assign empty    = count == '0;
    assign full     = count == CNT_W'(DEPTH);
    assign in_ready = ~full;
    assign rd_stb   = av.chipselect & ~av.read_n;
    assign wr_stb   = av.chipselect & ~av.write_n;
    assign pop      = rd_stb & (av.address == 2'd0) & ~empty;
    assign push     = in_valid & ~full;

    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    // A push rejected while full sets overflow and beats a same-cycle clear.
    assign overflow_nxt = (in_valid & full) |
                          (overflow & ~(wr_stb & (av.address == 2'd1) & av.writedata[18]));

`ifdef EVENT_FIFO_PIO_THRESH_IRQ_EN
    logic [CNT_W-1:0] thresh, thresh_nxt, thresh_eff;
    assign thresh_nxt   = (wr_stb & (av.address == 2'd3)) ? av.writedata[CNT_W-1:0] : thresh;
    assign thresh_eff   = (thresh_nxt == '0) ? CNT_W'(1) : thresh_nxt;
    assign irq_mask_nxt = (wr_stb & (av.address == 2'd2)) ? av.writedata[1:0] : irq_mask;
    assign irq_nxt      = (irq_mask_nxt[0] & (count_nxt != '0)) |
                          (irq_mask_nxt[1] & (count_nxt >= thresh_eff));
    assign addr3_word   = 32'(thresh);
`else
    assign irq_mask_nxt = (wr_stb & (av.address == 2'd2)) ? {1'b0, av.writedata[0]} : irq_mask;
    assign irq_nxt      = irq_mask_nxt[0] & (count_nxt != '0);
    assign addr3_word   = '0;
`endif

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= in_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr + AW'(pop);
            wr_ptr   <= wr_ptr + AW'(push);
            count    <= count_nxt;
            overflow <= overflow_nxt;
            irq_mask <= irq_mask_nxt;
            irq      <= irq_nxt;
        end
    end

`ifdef EVENT_FIFO_PIO_THRESH_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            thresh <= CNT_W'(1);
        else
            thresh <= thresh_nxt;
    end
`endif

    // Stale memory behind an empty FIFO must never leak out, so DATA is gated on ~empty.
    assign data_word = empty ? '0 : (32'(mem[rd_ptr]) | 32'h8000_0000);

    always_comb begin
        status_word            = '0;
        status_word[CNT_W-1:0] = count;
        status_word[16]        = empty;
        status_word[17]        = full;
        status_word[18]        = overflow;
    end

    assign av.readdata = (av.address == 2'd0) ? data_word :
                         (av.address == 2'd1) ? status_word :
                         (av.address == 2'd2) ? {30'b0, irq_mask} : addr3_word;
endmodule

// File: tb/tb_lab62soc_event_fifo_pio.sv
// tb_lab62soc_event_fifo_pio: directed bench with a queue-based reference model of the event FIFO PIO.
module tb_lab62soc_event_fifo_pio;
    localparam int DEPTH = 8;
`ifdef EVENT_FIFO_PIO_THRESH_IRQ_EN
    localparam bit [1:0] MASK_BITS = 2'b11;
`else
    localparam bit [1:0] MASK_BITS = 2'b01;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       irq;

    always #5 clk = ~clk;

    lab62soc_event_fifo_pio_if bus();

    lab62soc_event_fifo_pio #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .av       (bus),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .irq      (irq)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue plus the few architectural registers.
    logic [7:0] q[$];
    bit         m_ovf;
    bit [1:0]   m_mask;
    int         m_th;
    bit         m_irq;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_ovf  = 0;
            m_mask = 0;
            m_th   = 1;
            m_irq  = 0;
        end else begin
            bit rd, wr, was_full, do_pop, do_push;
            int th_eff;
            rd       = bus.chipselect && !bus.read_n;
            wr       = bus.chipselect && !bus.write_n;
            was_full = q.size() == DEPTH;
            do_pop   = rd && bus.address == 2'd0 && q.size() != 0;
            do_push  = in_valid && !was_full;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(in_data);
            if (wr && bus.address == 2'd1 && bus.writedata[18]) m_ovf = 0;
            if (in_valid && was_full) m_ovf = 1;
            if (wr && bus.address == 2'd2) m_mask = bus.writedata[1:0] & MASK_BITS;
`ifdef EVENT_FIFO_PIO_THRESH_IRQ_EN
            if (wr && bus.address == 2'd3) m_th = int'(bus.writedata[3:0]);
`endif
            th_eff = (m_th == 0) ? 1 : m_th;
            m_irq  = (m_mask[0] && q.size() != 0) || (m_mask[1] && q.size() >= th_eff);
        end
    end

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic [31:0] r;
        r = 0;
        if (a == 2'd0 && q.size() != 0) r = 32'h8000_0000 | 32'(q[0]);
        if (a == 2'd1) r = q.size() | ((q.size() == 0) << 16) | ((q.size() == DEPTH) << 17) | (m_ovf << 18);
        if (a == 2'd2) r = 32'(m_mask);
`ifdef EVENT_FIFO_PIO_THRESH_IRQ_EN
        if (a == 2'd3) r = m_th;
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            chk("in_ready", in_ready, q.size() < DEPTH);
            chk("irq", irq, m_irq);
            if (bus.chipselect && !bus.read_n) chk("readdata", bus.readdata, exp_rd(bus.address));
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit w,
                       input logic [1:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        in_valid       = v;
        in_data        = d;
        bus.chipselect = r | w;
        bus.read_n     = !r;
        bus.write_n    = !w;
        bus.address    = a;
        bus.writedata  = wd;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 8'h00, 0, 0, 2'd0, 0);
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1, d, 0, 0, 2'd0, 0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(0, 8'h00, 0, 1, a, d);
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        cyc(0, 8'h00, 1, 0, a, 0);
        chk(name, bus.readdata, exp);
    endtask

    initial begin
        in_valid = 0; in_data = 0;
        bus.chipselect = 0; bus.read_n = 1; bus.write_n = 1; bus.address = 0; bus.writedata = 0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1;

        rd("rst_data", 2'd0, 32'h0000_0000);
        rd("rst_status", 2'd1, 32'h0001_0000);
        rd("rst_mask", 2'd2, 32'h0000_0000);
        rd("rst_addr3", 2'd3, 32'h0000_0001 & {32{MASK_BITS[1]}});
        chk("rst_in_ready", in_ready, 1);
        chk("rst_irq", irq, 0);

        push(8'h11); push(8'h22); push(8'h33);
        rd("pop1", 2'd0, 32'h8000_0011);
        rd("pop2", 2'd0, 32'h8000_0022);
        rd("pop3", 2'd0, 32'h8000_0033);
        rd("pop_empty", 2'd0, 32'h0000_0000);
        rd("status_empty", 2'd1, 32'h0001_0000);

        for (int i = 0; i < 9; i++) begin
            push(8'hA0 + 8'(i));
            if (i == 8) chk("full_in_ready", in_ready, 0);
        end
        rd("status_ovf", 2'd1, 32'h0006_0008);
        wr(2'd1, 32'h0004_0000);
        rd("status_ovf_clr", 2'd1, 32'h0002_0008);

        cyc(1, 8'hBB, 1, 0, 2'd0, 0);
        chk("full_pushpop_data", bus.readdata, 32'h8000_00A0);
        rd("full_pushpop_status", 2'd1, 32'h0004_0007);
        wr(2'd1, 32'h0004_0000);
        for (int i = 1; i < 5; i++) rd("drain", 2'd0, 32'h8000_00A0 + i);
        cyc(1, 8'hC1, 1, 0, 2'd0, 0);
        chk("pushpop_data", bus.readdata, 32'h8000_00A5);
        rd("pushpop_status", 2'd1, 32'h0000_0003);
        rd("order1", 2'd0, 32'h8000_00A6);
        rd("order2", 2'd0, 32'h8000_00A7);
        rd("order3", 2'd0, 32'h8000_00C1);
        rd("order_empty", 2'd1, 32'h0001_0000);

        wr(2'd2, 1);
        rd("mask_rd", 2'd2, 1);
        push(8'h55);
        chk("irq_push_cycle", irq, 0);
        idle();
        chk("irq_rise", irq, 1);
        rd("irq_pop", 2'd0, 32'h8000_0055);
        chk("irq_during_pop", irq, 1);
        idle();
        chk("irq_fall", irq, 0);

        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        idle();
        chk("pre_reset_irq", irq, 1);
        @(posedge clk);
        #2 reset_n = 0;
        #1 chk("async_irq", irq, 0);
        chk("async_in_ready", in_ready, 1);
        bus.chipselect = 1; bus.read_n = 0; bus.address = 2'd1;
        #1 chk("async_status", bus.readdata, 32'h0001_0000);
        bus.chipselect = 0; bus.read_n = 1;
        @(negedge clk);
        #1 reset_n = 1;
        rd("post_rst_status", 2'd1, 32'h0001_0000);
        rd("post_rst_mask", 2'd2, 0);

`ifdef EVENT_FIFO_PIO_THRESH_IRQ_EN
        wr(2'd3, 4);
        rd("thresh_rd", 2'd3, 4);
        wr(2'd2, 2);
        push(8'h01); push(8'h02); push(8'h03);
        idle();
        chk("thr_below", irq, 0);
        push(8'h04);
        idle();
        chk("thr_hit", irq, 1);
        rd("thr_pop", 2'd0, 32'h8000_0001);
        idle();
        chk("thr_drop", irq, 0);
        wr(2'd3, 0);
        idle();
        chk("thr_zero", irq, 1);
`else
        wr(2'd3, 5);
        rd("addr3_ignored", 2'd3, 0);
        wr(2'd2, 3);
        rd("mask_bit1_ro", 2'd2, 1);
`endif
        idle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
